// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: SRAM-like cache port to single-beat AXI4 bridge, one transaction outstanding.
// Define SRAM_AXI_BRIDGE_RESP_CHECK_EN to add sticky bus_err / bus_err_addr capture.
module sram_axi_bridge #(
    parameter int AXI_ID_WIDTH = 4,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = 4'd1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req,
    input  logic                    wr,
    input  logic [1:0]              size,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [AXI_ID_WIDTH-1:0] arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [31:0]             rdata_axi,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [AXI_ID_WIDTH-1:0] awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [AXI_ID_WIDTH-1:0] wid,
    output logic [31:0]             wdata_axi,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
`ifdef SRAM_AXI_BRIDGE_RESP_CHECK_EN
    ,
    output logic                    bus_err,
    output logic [31:0]             bus_err_addr
`endif
);
    typedef enum logic [2:0] {IDLE, AR, R, WA, B} state_t;
    state_t state, state_nx;
    logic [31:0] addr_q, wdata_q;
    logic [1:0] size_q;
    logic [3:0] wstrb_q, wstrb_nx;
    logic aw_done, w_done, aw_hs, w_hs, go_b, accept;
    assign addr_ok = state == IDLE;
    assign accept = req && addr_ok;
    assign arvalid = state == AR;
    assign rready = state == R;
    assign awvalid = state == WA && !aw_done;
    assign wvalid = state == WA && !w_done;
    assign bready = state == B;
    assign data_ok = (rready && rvalid) || (bready && bvalid);
    assign rdata = rdata_axi;
    assign aw_hs = awvalid && awready;
    assign w_hs = wvalid && wready;
    // Either channel may have finished in an earlier cycle.
    assign go_b = state == WA && (aw_done || aw_hs) && (w_done || w_hs);
    assign wstrb_nx = size[1] ? 4'b1111 : (size[0] ? 4'b0011 : 4'b0001) << addr[1:0];
    assign arid = AXI_ID;
    assign awid = AXI_ID;
    assign wid = AXI_ID;
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arlen = 8'd0;
    assign awlen = 8'd0;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wdata_axi = wdata_q;
    assign wstrb = wstrb_q;
    assign wlast = 1'b1;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req ? (wr ? WA : AR) : IDLE;
            AR:      state_nx = arready ? R : AR;
            R:       state_nx = rvalid ? IDLE : R;
            WA:      state_nx = go_b ? B : WA;
            B:       state_nx = bvalid ? IDLE : B;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            addr_q <= '0;
            size_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q <= addr;
                size_q <= size;
                wdata_q <= wdata;
                wstrb_q <= wstrb_nx;
            end
            aw_done <= go_b ? 1'b0 : aw_done || aw_hs;
            w_done <= go_b ? 1'b0 : w_done || w_hs;
        end
    end
`ifdef SRAM_AXI_BRIDGE_RESP_CHECK_EN
    logic err_now, unused;
    assign unused = rlast;
    assign err_now = (rready && rvalid && rresp != 2'b00) || (bready && bvalid && bresp != 2'b00);
    // Only the first failing completion is recorded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_err <= 1'b0;
            bus_err_addr <= '0;
        end else if (err_now && !bus_err) begin
            bus_err <= 1'b1;
            bus_err_addr <= addr_q;
        end
    end
`else
    logic unused;
    assign unused = ^{rlast, rresp, bresp};
`endif
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: directed and randomized checks of sram_axi_bridge against a transaction-level model.
module tb_sram_axi_bridge;
    logic clk = 1'b0, resetn = 1'b0;
    logic req, wr, addr_ok, data_ok;
    logic [1:0] size;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] arid, awid, wid;
    logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic [3:0] wstrb;
    logic wlast, wvalid, wready, bvalid, bready;
`ifdef SRAM_AXI_BRIDGE_RESP_CHECK_EN
    logic bus_err;
    logic [31:0] bus_err_addr;
`endif
    int errors = 0, checks = 0, dok_cnt = 0;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready), .wid(wid),
        .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef SRAM_AXI_BRIDGE_RESP_CHECK_EN
        , .bus_err(bus_err), .bus_err_addr(bus_err_addr)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (data_ok === 1'b1) dok_cnt <= dok_cnt + 1;

    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    task automatic smp;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_strb(input logic [1:0] s, input logic [31:0] a);
        int bytes;
        bytes = 1 << s;
        return s[1] ? 4'hF : 4'(((1 << bytes) - 1) << a[1:0]);
    endfunction

    task automatic idle_in;
        req = 0; wr = 0; size = 0; addr = 0; wdata = 0;
        arready = 0; rvalid = 0; rdata_axi = 0; rresp = 0; rlast = 1;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    task automatic test_reset;
        idle_in();
        resetn = 0;
        repeat (2) nxt();
        smp();
        checks++;
        if ({addr_ok, arvalid, awvalid, wvalid, data_ok, rready, bready} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 1000000", {addr_ok, arvalid, awvalid, wvalid, data_ok, rready, bready});
        end
        checks++;
        if ({araddr, awaddr, wdata_axi, wstrb, arsize} !== 103'd0) begin
            errors++;
            $display("FAIL reset_regs: got %h %h %h %h %h want all zero", araddr, awaddr, wdata_axi, wstrb, arsize);
        end
        checks++;
        if ({arlen, awlen, arburst, awburst, arid, awid, wid, wlast} !== {8'd0, 8'd0, 2'b01, 2'b01, 4'd1, 4'd1, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL reset_const: got len=%h/%h burst=%b/%b id=%h/%h/%h wlast=%b", arlen, awlen, arburst, awburst, arid, awid, wid, wlast);
        end
`ifdef SRAM_AXI_BRIDGE_RESP_CHECK_EN
        checks++;
        if ({bus_err, bus_err_addr} !== 33'd0) begin
            errors++;
            $display("FAIL reset_err: got %b %h want 0 0", bus_err, bus_err_addr);
        end
`endif
        nxt();
        resetn = 1;
    endtask

    task automatic test_read_word;
        int d0;
        nxt(); req = 1; wr = 0; size = 2; addr = 32'h1FC0_0010; arready = 1;
        smp(); d0 = dok_cnt;
        checks++;
        if ({addr_ok, data_ok} !== 2'b10) begin errors++; $display("FAIL rd_accept: got %b want 10", {addr_ok, data_ok}); end
        nxt(); req = 0; addr = 32'hFFFF_FFFF;
        smp();
        checks++;
        if ({addr_ok, arvalid, araddr, arsize, awvalid} !== {1'b0, 1'b1, 32'h1FC0_0010, 3'b010, 1'b0}) begin
            errors++;
            $display("FAIL rd_ar: got ok=%b arv=%b a=%h sz=%b awv=%b want 0 1 1fc00010 010 0", addr_ok, arvalid, araddr, arsize, awvalid);
        end
        nxt(); rvalid = 1; rdata_axi = 32'hDEAD_BEEF;
        smp();
        checks++;
        if ({arvalid, rready, data_ok, rdata} !== {3'b011, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_data: got arv=%b rr=%b ok=%b d=%h want 0 1 1 deadbeef", arvalid, rready, data_ok, rdata);
        end
        nxt(); rvalid = 0; rdata_axi = 0; arready = 0;
        smp();
        checks++;
        if ({addr_ok, data_ok} !== 2'b10 || dok_cnt - d0 != 1) begin
            errors++;
            $display("FAIL rd_done: got ok=%b dok=%b pulses=%0d want 1 0 1", addr_ok, data_ok, dok_cnt - d0);
        end
    endtask

    task automatic test_byte_write;
        int d0;
        nxt(); req = 1; wr = 1; size = 0; addr = 32'h0000_0103; wdata = 32'hAB00_0000; awready = 1; wready = 1;
        smp(); d0 = dok_cnt;
        nxt(); req = 0; addr = 0; wdata = 0;
        smp();
        checks++;
        if ({awvalid, wvalid, awaddr, wstrb, wdata_axi, wlast, awsize} !== {2'b11, 32'h103, 4'b1000, 32'hAB00_0000, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL bw_aw: got v=%b%b a=%h s=%b d=%h l=%b sz=%b want 11 103 1000 ab000000 1 000", awvalid, wvalid, awaddr, wstrb, wdata_axi, wlast, awsize);
        end
        nxt(); awready = 0; wready = 0;
        smp();
        checks++;
        if ({awvalid, wvalid, bready, data_ok} !== 4'b0010) begin
            errors++;
            $display("FAIL bw_wait_b: got %b want 0010", {awvalid, wvalid, bready, data_ok});
        end
        nxt(); bvalid = 1;
        smp();
        checks++;
        if ({bready, data_ok} !== 2'b11) begin errors++; $display("FAIL bw_b: got %b want 11", {bready, data_ok}); end
        nxt(); bvalid = 0;
        smp();
        checks++;
        if (addr_ok !== 1'b1 || dok_cnt - d0 != 1) begin
            errors++;
            $display("FAIL bw_done: got ok=%b pulses=%0d want 1 1", addr_ok, dok_cnt - d0);
        end
    endtask

    task automatic test_split_write;
        nxt(); req = 1; wr = 1; size = 2; addr = 32'h0000_0040; wdata = 32'h1122_3344; wready = 1;
        smp();
        nxt(); req = 0; addr = 32'h5555_5555;
        smp();
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL sw_c1: got %b want 11", {awvalid, wvalid}); end
        for (int c = 2; c <= 4; c++) begin
            nxt(); awready = (c == 4);
            smp();
            checks++;
            if ({awvalid, wvalid, bready, awaddr} !== {3'b100, 32'h40}) begin
                errors++;
                $display("FAIL sw_c%0d: got v=%b%b b=%b a=%h want 10 0 40", c, awvalid, wvalid, bready, awaddr);
            end
        end
        nxt(); awready = 0; wready = 0; bvalid = 1;
        smp();
        checks++;
        if ({awvalid, wvalid, bready, data_ok} !== 4'b0011) begin errors++; $display("FAIL sw_c5: got %b want 0011", {awvalid, wvalid, bready, data_ok}); end
        nxt(); bvalid = 0;
        smp();
    endtask

    task automatic test_back_to_back;
        nxt(); req = 1; wr = 0; size = 2; addr = 32'h100; arready = 1;
        smp();
        nxt(); req = 0;
        smp();
        nxt(); rvalid = 1; rdata_axi = 32'h5A5A_1234;
        smp();
        checks++;
        if ({data_ok, rdata} !== {1'b1, 32'h5A5A_1234}) begin errors++; $display("FAIL b2b_rd: got %b %h want 1 5a5a1234", data_ok, rdata); end
        nxt(); rvalid = 0; arready = 0; req = 1; wr = 1; size = 1; addr = 32'h2; wdata = 32'hBEEF_0000; awready = 1; wready = 1;
        smp();
        checks++;
        if ({addr_ok, arvalid, rready, awvalid} !== 4'b1000) begin errors++; $display("FAIL b2b_accept: got %b want 1000", {addr_ok, arvalid, rready, awvalid}); end
        nxt(); req = 0;
        smp();
        checks++;
        if ({awvalid, wvalid, arvalid, wstrb, awaddr, awsize} !== {3'b110, 4'b1100, 32'h2, 3'b001}) begin
            errors++;
            $display("FAIL b2b_wr: got v=%b%b%b s=%b a=%h sz=%b want 110 1100 2 001", awvalid, wvalid, arvalid, wstrb, awaddr, awsize);
        end
        nxt(); awready = 0; wready = 0; bvalid = 1;
        smp();
        checks++;
        if ({bready, data_ok, arvalid} !== 3'b110) begin errors++; $display("FAIL b2b_b: got %b want 110", {bready, data_ok, arvalid}); end
        nxt(); bvalid = 0;
        smp();
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            logic t_wr, ar_p, r_p, aw_p, w_p, b_p, done;
            logic [1:0] t_sz;
            logic [31:0] t_a, t_d, t_r;
            int dar, dr, daw, dw, db, war, wrr, waw, ww, wb;
            t_wr = 1'($urandom); t_sz = 2'($urandom); t_a = $urandom; t_d = $urandom; t_r = $urandom;
            dar = $urandom_range(0, 3); dr = $urandom_range(0, 3); daw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3); db = $urandom_range(0, 3);
            war = 0; wrr = 0; waw = 0; ww = 0; wb = 0;
            ar_p = !t_wr; r_p = 0; aw_p = t_wr; w_p = t_wr; b_p = 0; done = 0;
            nxt(); idle_in(); req = 1; wr = t_wr; size = t_sz; addr = t_a; wdata = t_d;
            smp();
            checks++;
            if (addr_ok !== 1'b1) begin errors++; $display("FAIL rnd_accept %0d: got %b want 1", n, addr_ok); end
            for (int c = 0; c < 30 && !done; c++) begin
                nxt(); req = 0; wr = 1'($urandom); addr = $urandom; wdata = $urandom; size = 2'($urandom);
                arready = ar_p && war >= dar; rvalid = r_p && wrr >= dr; rdata_axi = t_r;
                awready = aw_p && waw >= daw; wready = w_p && ww >= dw; bvalid = b_p && wb >= db;
                smp();
                checks++;
                if ({addr_ok, arvalid, rready, awvalid, wvalid, bready, data_ok} !== {1'b0, ar_p, r_p, aw_p, w_p, b_p, (r_p && rvalid) || (b_p && bvalid)}) begin
                    errors++;
                    $display("FAIL rnd_ctrl %0d/%0d: got %b want %b", n, c, {addr_ok, arvalid, rready, awvalid, wvalid, bready, data_ok},
                             {1'b0, ar_p, r_p, aw_p, w_p, b_p, (r_p && rvalid) || (b_p && bvalid)});
                end
                checks++;
                if ({araddr, awaddr, arsize, awsize, wdata_axi, wstrb} !== {t_a, t_a, 1'b0, t_sz, 1'b0, t_sz, t_d, exp_strb(t_sz, t_a)}) begin
                    errors++;
                    $display("FAIL rnd_latch %0d: got a=%h/%h sz=%b/%b d=%h s=%b want %h %b %h %b", n, araddr, awaddr, arsize, awsize,
                             wdata_axi, wstrb, t_a, t_sz, t_d, exp_strb(t_sz, t_a));
                end
                if (r_p && rvalid) begin
                    checks++;
                    if (rdata !== t_r) begin errors++; $display("FAIL rnd_rdata %0d: got %h want %h", n, rdata, t_r); end
                end
                if (r_p) begin if (rvalid) done = 1; else wrr++; end
                if (b_p) begin if (bvalid) done = 1; else wb++; end
                if (ar_p) begin if (arready) begin ar_p = 0; r_p = 1; end else war++; end
                if (aw_p) begin if (awready) aw_p = 0; else waw++; end
                if (w_p) begin if (wready) w_p = 0; else ww++; end
                if (t_wr && !aw_p && !w_p && !done) b_p = 1;
            end
            checks++;
            if (!done) begin errors++; $display("FAIL rnd_timeout %0d: got no completion want completion", n); end
        end
        nxt(); idle_in();
        smp();
`ifdef SRAM_AXI_BRIDGE_RESP_CHECK_EN
        checks++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL rnd_no_err: got %b want 0", bus_err); end
`endif
    endtask

`ifdef SRAM_AXI_BRIDGE_RESP_CHECK_EN
    task automatic test_resp_check;
        nxt(); req = 1; wr = 1; size = 2; addr = 32'h8000_0040; awready = 1; wready = 1;
        smp();
        nxt(); req = 0; addr = 0;
        smp();
        nxt(); awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
        smp();
        checks++;
        if (data_ok !== 1'b1) begin errors++; $display("FAIL err_dok: got %b want 1", data_ok); end
        nxt(); bvalid = 0; bresp = 0;
        smp();
        checks++;
        if ({bus_err, bus_err_addr} !== {1'b1, 32'h8000_0040}) begin errors++; $display("FAIL err_set: got %b %h want 1 80000040", bus_err, bus_err_addr); end
        nxt(); req = 1; wr = 0; addr = 32'h0000_1234; arready = 1;
        smp();
        nxt(); req = 0; arready = 0;
        smp();
        nxt(); rvalid = 1; rresp = 2'b11;
        smp();
        checks++;
        if (data_ok !== 1'b1) begin errors++; $display("FAIL err2_dok: got %b want 1", data_ok); end
        nxt(); rvalid = 0; rresp = 0;
        smp();
        checks++;
        if ({bus_err, bus_err_addr} !== {1'b1, 32'h8000_0040}) begin errors++; $display("FAIL err_sticky: got %b %h want 1 80000040", bus_err, bus_err_addr); end
    endtask
`endif

    task automatic test_reset_mid;
        int d0;
        nxt(); idle_in(); req = 1; wr = 0; size = 2; addr = 32'h300;
        smp();
        nxt(); req = 0;
        smp(); d0 = dok_cnt;
        checks++;
        if (arvalid !== 1'b1) begin errors++; $display("FAIL rm_ar: got %b want 1", arvalid); end
        nxt(); resetn = 0;
        #1;
        checks++;
        if ({arvalid, addr_ok, data_ok} !== 3'b010) begin errors++; $display("FAIL rm_async: got %b want 010", {arvalid, addr_ok, data_ok}); end
        nxt(); resetn = 1;
        smp();
        checks++;
        if ({addr_ok, arvalid, araddr} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rm_idle: got %b %b %h want 1 0 0", addr_ok, arvalid, araddr); end
        nxt(); arready = 1; rvalid = 1;
        smp();
        checks++;
        if ({arvalid, rready, data_ok} !== 3'b000 || dok_cnt != d0) begin
            errors++;
            $display("FAIL rm_quiet: got %b pulses=%0d want 000 0", {arvalid, rready, data_ok}, dok_cnt - d0);
        end
`ifdef SRAM_AXI_BRIDGE_RESP_CHECK_EN
        checks++;
        if ({bus_err, bus_err_addr} !== 33'd0) begin errors++; $display("FAIL rm_err_clr: got %b %h want 0 0", bus_err, bus_err_addr); end
`endif
        nxt(); idle_in();
    endtask

    initial begin
        test_reset();
        test_read_word();
        test_byte_write();
        test_split_write();
        test_back_to_back();
        test_random();
`ifdef SRAM_AXI_BRIDGE_RESP_CHECK_EN
        test_resp_check();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
